// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder: access widths, FSM states,
// wait-counter type and address-alignment helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_W_BYTE = 2'b00,
        MEM_W_HALF = 2'b01,
        MEM_W_WORD = 2'b10,
        MEM_W_RSVD = 2'b11
    } mem_width_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } mem_state_e;

    typedef logic [3:0] mem_cnt_t;

    // Reserved width (11) is handled exactly like a word access.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lo);
        logic bad;
        case (width)
            MEM_W_BYTE: bad = 1'b0;
            MEM_W_HALF: bad = lo[0];
            default:    bad = (lo != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [1:0] align_lo(input logic [1:0] width, input logic [1:0] lo);
        logic [1:0] al;
        case (width)
            MEM_W_BYTE: al = lo;
            MEM_W_HALF: al = {lo[1], 1'b0};
            default:    al = 2'b00;
        endcase
        return al;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store bus between the pipeline memory stage (master) and the data RAM (slave).
// The fault signal exists only when MEM_MISALIGN_CHECK_EN is defined.
interface data_mem_responder_if;

    logic        req;
    logic [31:0] addr;
    logic        write;
    logic [31:0] data_out;
    logic        extend;
    logic [1:0]  width;
    logic        ack;
    logic [31:0] data_in;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        fault;
`endif

    modport master (
        output req, addr, write, data_out, extend, width,
`ifdef MEM_MISALIGN_CHECK_EN
        input  fault,
`endif
        input  ack, data_in
    );

    modport slave (
        input  req, addr, write, data_out, extend, width,
`ifdef MEM_MISALIGN_CHECK_EN
        output fault,
`endif
        output ack, data_in
    );

endinterface

// File: rtl/data_mem_responder_lane_align.sv
// Byte-lane steering: store data replication with byte enables, and load lane
// extraction with zero/sign extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  lo_i,
    input  logic [1:0]  width_i,
    input  logic        extend_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rd_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] st_word_o,
    output logic [31:0] ld_data_o
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic is_byte;
            logic is_half;

            assign is_byte = (width_i == MEM_W_BYTE);
            assign is_half = (width_i == MEM_W_HALF);

            assign be_o[gi] = is_byte ? (lo_i == LANE) :
                              is_half ? (lo_i[1] == LANE[1]) : 1'b1;

            // Halves put data_out[7:0] in the even lane and data_out[15:8] in the odd lane.
            assign st_word_o[gi*8 +: 8] = is_byte ? st_data_i[7:0] :
                                          is_half ? st_data_i[(gi%2)*8 +: 8] :
                                                    st_data_i[gi*8 +: 8];
        end
    endgenerate

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rd_word_i[{lo_i, 3'b000} +: 8];
        half_sel  = rd_word_i[{lo_i[1], 4'b0000} +: 16];
        ld_data_o = rd_word_i;
        case (width_i)
            MEM_W_BYTE: ld_data_o = {{24{extend_i & byte_sel[7]}}, byte_sel};
            MEM_W_HALF: ld_data_o = {{16{extend_i & half_sel[15]}}, half_sel};
            default:    ld_data_o = rd_word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering load/store requests after LATENCY wait states.
// MEM_MISALIGN_CHECK_EN: misaligned accesses ack with fault instead of being force-aligned.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam mem_cnt_t   LAT_M1   = mem_cnt_t'(LATENCY - 1);
    localparam mem_state_e FIRST_ST = (LATENCY == 1) ? ST_ACK : ST_WAIT;

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [31:0]      rd_word_q;

    mem_state_e       state_q;
    mem_cnt_t         cnt_q;
    mem_cnt_t         cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       lo_q;
    logic             write_q;
    logic             extend_q;
    logic [1:0]       width_q;
    logic [31:0]      wdata_q;
    logic             bad_q;
    logic             ack_q;
    logic [31:0]      data_in_q;

    logic [1:0]       cap_lo;
    logic             cap_bad;
    logic [IDX_W-1:0] rd_idx;
    logic             ram_we;
    logic [3:0]       be;
    logic [31:0]      st_word;
    logic [31:0]      ld_data;

    // Bits above the RAM index are dropped, so addresses wrap modulo the RAM size.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:IDX_W+2];

    always_comb begin
`ifdef MEM_MISALIGN_CHECK_EN
        cap_lo  = bus.addr[1:0];
        cap_bad = is_misaligned(bus.width, bus.addr[1:0]);
`else
        cap_lo  = align_lo(bus.width, bus.addr[1:0]);
        cap_bad = 1'b0;
`endif
        cnt_d  = cnt_q - 4'd1;
        // In IDLE the live address feeds the read port so the word is ready by ACK even at LATENCY 1.
        rd_idx = (state_q == ST_IDLE) ? bus.addr[IDX_W+1:2] : idx_q;
        ram_we = (state_q == ST_ACK) && write_q && !bad_q && !reset;
    end

    mem_lane_align u_align (
        .lo_i      (lo_q),
        .width_i   (width_q),
        .extend_i  (extend_q),
        .st_data_i (wdata_q),
        .rd_word_i (rd_word_q),
        .be_o      (be),
        .st_word_o (st_word),
        .ld_data_o (ld_data)
    );

    always_ff @(posedge clk) begin
        rd_word_q <= mem_q[rd_idx];
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx_q][b*8 +: 8] <= st_word[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            data_in_q <= '0;
            bad_q     <= 1'b0;
            idx_q     <= '0;
            lo_q      <= '0;
            write_q   <= 1'b0;
            extend_q  <= 1'b0;
            width_q   <= '0;
            wdata_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q <= 1'b0;
                    if (bus.req) begin
                        idx_q    <= bus.addr[IDX_W+1:2];
                        lo_q     <= cap_lo;
                        write_q  <= bus.write;
                        extend_q <= bus.extend;
                        width_q  <= bus.width;
                        wdata_q  <= bus.data_out;
                        bad_q    <= cap_bad;
                        cnt_q    <= LAT_M1;
                        state_q  <= FIRST_ST;
                        ack_q    <= (FIRST_ST == ST_ACK);
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == '0) begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                    end
                end
                ST_ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= ST_IDLE;
                    if (!write_q && !bad_q) begin
                        data_in_q <= ld_data;
                    end
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack     = ack_q;
    assign bus.data_in = data_in_q;
`ifdef MEM_MISALIGN_CHECK_EN
    assign bus.fault   = ack_q & bad_q;
`endif

endmodule
